one_detect_scheduler: RTL and testbench

Sequencing controller that time-multiplexes a single CHUNK_W-bit one-detector datapath (out = OR-reduce of its input) across a wide NUM_CHUNKS*CHUNK_W-bit word. It accepts one word per valid/ready handshake, feeds one chunk per cycle through the OR-reduction, and accumulates three results: any-one flag, index of the first nonzero chunk, and count of nonzero chunks. It sits between a wide-vector producer and a consumer that needs a zero/nonzero summary without instantiating NUM_CHUNKS detectors.

---
 rtl/one_detect_scheduler.sv | 115 +++++++++++
 tb/tb_one_detect_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/one_detect_scheduler.sv
// one_detect_scheduler
// Runs one CHUNK_W-bit OR-reduction over a NUM_CHUNKS*CHUNK_W-bit word,
// one chunk per cycle. It accumulates three results:
//   - whether any bit of the word is set
//   - the index of the first nonzero chunk
//   - the number of nonzero chunks
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   in_valid/in_ready    input word handshake; in_data holds the word
//   out_valid/out_ready  result handshake
//   out_any              any bit of the word was 1
//   out_first            lowest nonzero chunk index (0 if none)
//   out_count            number of nonzero chunks
//   busy                 high while scanning or holding a result
module one_detect_scheduler #(
  parameter int CHUNK_W    = 64,
  parameter int NUM_CHUNKS = 4,
  parameter int IDX_W      = $clog2(NUM_CHUNKS),
  parameter int CNT_W      = $clog2(NUM_CHUNKS + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_CHUNKS*CHUNK_W-1:0] in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_any,
  output logic [IDX_W-1:0]              out_first,
  output logic [CNT_W-1:0]              out_count,
  output logic                          busy
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  state_t                          state_q, state_d;
  logic [NUM_CHUNKS*CHUNK_W-1:0]   word_q, word_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic                            any_q, any_d;
  logic [IDX_W-1:0]                first_q, first_d;
  logic [CNT_W-1:0]                count_q, count_d;

  logic [CHUNK_W-1:0]              chunk;
  logic                            hit;

  // The single shared one-detector
  assign chunk = word_q[idx_q*CHUNK_W +: CHUNK_W];
  assign hit   = |chunk;

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_any   = any_q;
  assign out_first = first_q;
  assign out_count = count_q;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    any_d   = any_q;
    first_d = first_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          word_d  = in_data;
          idx_d   = '0;
          any_d   = 1'b0;
          first_d = '0;
          count_d = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (hit) begin
          count_d = count_q + CNT_W'(1);
          if (!any_q) begin
            first_d = idx_q;
            any_d   = 1'b1;
          end
        end
        // Index wraps after the last chunk; it is cleared on the next accept
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      any_q   <= 1'b0;
      first_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      any_q   <= any_d;
      first_q <= first_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_one_detect_scheduler.sv
module tb_one_detect_scheduler;

  localparam int W  = 64;
  localparam int N  = 4;
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(N + 1);
  localparam int DW = N * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_any;
  logic [IW-1:0] out_first;
  logic [CW-1:0] out_count;
  logic          busy;

  int checks = 0;
  int errors = 0;

  one_detect_scheduler #(
    .CHUNK_W    (W),
    .NUM_CHUNKS (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_any   (out_any),
    .out_first (out_first),
    .out_count (out_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: examine each chunk as an integer slice of the word
  task automatic model(input logic [DW-1:0] w, output int ea, output int ef, output int ec);
    logic [W-1:0] c;
    ea = 0; ef = 0; ec = 0;
    for (int k = 0; k < N; k++) begin
      c = w[k*W +: W];
      if (c != '0) begin
        if (ec == 0) ef = k;
        ec++;
      end
    end
    ea = (ec > 0) ? 1 : 0;
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Per chunk: zero, single random bit, or random contents
  function automatic logic [DW-1:0] mixed_word();
    logic [DW-1:0] w;
    logic [DW-1:0] r;
    w = '0;
    r = rand_word();
    for (int k = 0; k < N; k++) begin
      case ($urandom_range(2))
        0: w[k*W +: W] = '0;
        1: w[k*W + $urandom_range(W - 1)] = 1'b1;
        default: w[k*W +: W] = r[k*W +: W];
      endcase
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("in_ready_wait", in_ready, 1);
  endtask

  task automatic check_fields(input string tag, input int ea, input int ef, input int ec);
    check({tag, "_any"},   out_any,   ea);
    check({tag, "_first"}, out_first, ef);
    check({tag, "_count"}, out_count, ec);
  endtask

  task automatic run_word(input logic [DW-1:0] w, input int stall);
    int ea, ef, ec, n;
    model(w, ea, ef, ec);
    wait_ready();
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
    in_data  = rand_word();
    check("busy_scan", busy, 1);
    check("in_ready_scan", in_ready, 0);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      in_data = rand_word();
      n++;
    end
    check("latency", n, N);
    check_fields("done", ea, ef, ec);
    for (int s = 0; s < stall; s++) begin
      tick();
      check("stall_valid", out_valid, 1);
      check("stall_busy", busy, 1);
      check("stall_in_ready", in_ready, 0);
      check_fields("stall", ea, ef, ec);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
    check("post_busy", busy, 0);
    check_fields("hold", ea, ef, ec);
  endtask

  logic [DW-1:0] w, w1, w2;
  int ea, ef, ec, n, cyc, accepts, pulses;
  int acc_cyc[2];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check_fields("rst", 0, 0, 0);
    rst = 1'b0;
    #1;
    check("rst_release_ready", in_ready, 1);

    // Directed words
    run_word('0, 0);
    w = '0; w[50] = 1'b1;                   run_word(w, 0);
    w = '0; w[255] = 1'b1;                  run_word(w, 1);
    w = '0; w[70] = 1'b1; w[200] = 1'b1; w[201] = 1'b1; run_word(w, 0);
    run_word('1, 3);

    // Reset during the second SCAN cycle
    wait_ready();
    w = rand_word();
    in_valid = 1'b1; in_data = w;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("midrst_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    check_fields("midrst", 0, 0, 0);
    rst = 1'b0;
    #1;
    check("midrst_release_ready", in_ready, 1);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) pulses++;
    end
    check("midrst_no_valid", pulses, 0);
    w = '0; w[130] = 1'b1; run_word(w, 0);

    // Back-to-back with in_valid and out_ready held high
    w1 = mixed_word();
    w2 = mixed_word();
    w2[3*W] = ~w1[3*W];
    wait_ready();
    in_valid = 1'b1; in_data = w1; out_ready = 1'b1;
    cyc = 0; accepts = 0; pulses = 0;
    while (cyc < 40 && pulses < 2) begin
      if (in_valid && in_ready && accepts < 2) begin
        acc_cyc[accepts] = cyc;
        accepts++;
      end
      tick();
      cyc++;
      if (accepts == 1) in_data = w2;
      if (accepts == 2) in_valid = 1'b0;
      if (out_valid) begin
        model((pulses == 0) ? w1 : w2, ea, ef, ec);
        check_fields("b2b", ea, ef, ec);
        pulses++;
        tick();
        cyc++;
        check("b2b_one_cycle_valid", out_valid, 0);
        if (accepts == 2) in_valid = 1'b0;
      end
    end
    check("b2b_accepts", accepts, 2);
    check("b2b_pulses", pulses, 2);
    check("b2b_spacing", acc_cyc[1] - acc_cyc[0], N + 2);
    out_ready = 1'b0; in_valid = 1'b0;

    // Randomized words and stalls
    for (int t = 0; t < 25; t++) begin
      w = ($urandom_range(4) == 0) ? rand_word() : mixed_word();
      run_word(w, $urandom_range(3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
